fir_coeff_loader: RTL and testbench
===================================

# fir_coeff_loader

Coefficient-update sequencer that sits directly upstream of the reconfigurable FIR filter. It accepts a stream of 40 16-bit tap coefficients over a valid/ready handshake. It raises the filter's coefficient-update flag, waits for the filter to enter update mode, and then writes each coefficient into the filter's RAM port one word per cycle, linearly at addresses 0..39. It also reports completion, a running checksum, and abort/timeout errors to the host.

## Interface
Parameters:
- NUM_TAPS, 40, number of coefficients per session (10 per RAM × 4 RAMs)
- COEFF_W, 16, coefficient width
- ADDR_W, 6, RAM address width
- ARM_CYC, 2, cycles the update flag is held before the first write is accepted
- TIMEOUT, 4095, maximum consecutive LOAD cycles without an accepted word

Ports:
- iClk12M  in  1  12 MHz clock; the only clock
- iRsn  in  1  synchronous, active-high reset (1 = reset)
- iStart  in  1  pulse; starts a session when the block is idle
- iAbort  in  1  terminates the active session
- iCoeffValid  in  1  host coefficient valid
- iCoeff  in  COEFF_W  host coefficient data
- oCoeffReady  out  1  block accepts iCoeff this cycle
- oCoeffUpdateFlag  out  1  drives the filter's iCoeffUpdateFlag
- oCsnRam  out  1  RAM chip select, active low
- oWrnRam  out  1  RAM write enable, active low
- oAddrRam  out  ADDR_W  RAM address
- oWtDtRam  out  COEFF_W  RAM write data
- oBusy  out  1  session in progress
- oDone  out  1  one-cycle pulse on successful completion
- oErr  out  1  one-cycle pulse on abort or timeout
- oChecksum  out  16  sum of the words accepted this session, mod 2^16

## Operation
- States: IDLE, ARM, LOAD, SETTLE.
- IDLE
  - iStart=1 moves to ARM.
  - On entry to ARM: oCoeffUpdateFlag=1, oBusy=1, word counter=0, oChecksum=0.
- ARM
  - Lasts exactly ARM_CYC cycles, then moves to LOAD.
  - oCoeffReady=0 throughout.
- LOAD
  - oCoeffReady = (state==LOAD) & ~iAbort. This is combinational.
  - An accept is iCoeffValid & oCoeffReady.
  - On each accept: register the write (oAddrRam=counter, oWtDtRam=iCoeff, oCsnRam=0, oWrnRam=0) for one cycle, increment the counter, and add iCoeff to oChecksum.
  - Cycles with no accept: oCsnRam=1, oWrnRam=1; oAddrRam and oWtDtRam hold their last values.
  - The accept that makes the counter reach NUM_TAPS moves to SETTLE.
- SETTLE
  - Lasts one cycle, during which the final write pulse is on the RAM port.
  - Next: IDLE with oCoeffUpdateFlag=0, oBusy=0, oDone=1 for one cycle.
- Timeout
  - A counter clears on every accept and on entry to LOAD.
  - It increments on every LOAD cycle without an accept.
  - When it reaches TIMEOUT: go to IDLE, oErr=1 for one cycle.
- Abort
  - iAbort=1 in ARM, LOAD or SETTLE takes effect on the next cycle: IDLE, oCoeffUpdateFlag=0, oCsnRam=1, oWrnRam=1, oBusy=0, oErr=1 for one pulse.
  - iAbort in IDLE is ignored.
- iStart while oBusy=1 is ignored.
- oChecksum holds its value after done or error until the next iStart.
- RAM words written before an abort are left in place. The next session restarts at address 0.

## Timing
- Reset values (the cycle after iRsn=1): state IDLE, oCsnRam=1, oWrnRam=1, oAddrRam=0, oWtDtRam=0, oCoeffUpdateFlag=0, oCoeffReady=0, oBusy=0, oDone=0, oErr=0, oChecksum=0, all counters 0.
- Reset mid-session follows the same rule: idle the next cycle, with no oErr pulse.
- iStart at cycle t:
  - oCoeffUpdateFlag=1 at t+1.
  - oCoeffReady=1 from t+1+ARM_CYC.
- Accept at cycle n: write pulse on the RAM port at n+1, exactly one cycle wide.
- Throughput: back-to-back accepts give one write per cycle. The minimum session is ARM_CYC + NUM_TAPS + 1 cycles from the flag rising to oDone.
- Final accept at cycle n:
  - oCoeffReady=0 from n+1.
  - Write to address NUM_TAPS-1 at n+1.
  - At n+2: oCoeffUpdateFlag=0 and oDone=1.
  - A new iStart is accepted from n+2.
- iAbort and a valid word in the same cycle: abort wins. oCoeffReady=0, so the word is not written and not added to the checksum.
- Timeout and an accept in the same cycle: the accept wins and the timeout counter clears.

## Test plan
- Reset: hold iRsn=1 for 3 cycles with random inputs → every output at its reset value; no RAM write pulse.
- Full load: iStart, then 0x0001..0x0028 with valid held high → flag rises 1 cycle after iStart; ready at +3; 40 write pulses on consecutive cycles at addresses 0..39 with data = address+1; oChecksum=0x0334; oDone 2 cycles after the last accept, with the flag falling in the same cycle.
- Backpressure: valid asserted every other cycle, with coefficients 0xFFFF → writes only on accepts; addresses contiguous 0..39; oChecksum=0xFFD8; no oErr.
- Abort: abort asserted in the same cycle as the 11th word (value 0x1234) → exactly 10 writes (addresses 0..9); 0x1234 not written; oErr pulse and flag=0 the next cycle; a new session writes address 0 first.
- Timeout (TIMEOUT=16): stop valid after 5 words → oErr exactly 16 LOAD cycles after the 5th accept; flag drops; no further writes.
- Ignored start and mid-session reset: iStart pulsed during LOAD → no restart, address sequence continues; iRsn=1 during LOAD → idle outputs the next cycle, no oErr, no oDone.

Source files
------------

// File: rtl/fir_coeff_loader_if.sv
// Host/filter-side bundle of the coefficient loader: start/abort control, the
// coefficient valid/ready stream, the filter RAM write port and session status.
interface fir_coeff_loader_if #(
    parameter int COEFF_W = 16,
    parameter int ADDR_W  = 6
);
    logic               iStart;
    logic               iAbort;
    logic               iCoeffValid;
    logic [COEFF_W-1:0] iCoeff;
    logic               oCoeffReady;
    logic               oCoeffUpdateFlag;
    logic               oCsnRam;
    logic               oWrnRam;
    logic [ADDR_W-1:0]  oAddrRam;
    logic [COEFF_W-1:0] oWtDtRam;
    logic               oBusy;
    logic               oDone;
    logic               oErr;
    logic [15:0]        oChecksum;

    modport master (
        output iStart, iAbort, iCoeffValid, iCoeff,
        input  oCoeffReady, oCoeffUpdateFlag, oCsnRam, oWrnRam, oAddrRam,
               oWtDtRam, oBusy, oDone, oErr, oChecksum
    );

    modport slave (
        input  iStart, iAbort, iCoeffValid, iCoeff,
        output oCoeffReady, oCoeffUpdateFlag, oCsnRam, oWrnRam, oAddrRam,
               oWtDtRam, oBusy, oDone, oErr, oChecksum
    );
endinterface

// File: rtl/fir_coeff_loader.sv
// Coefficient-update sequencer: raises the filter update flag, waits ARM_CYC
// cycles, then streams NUM_TAPS host words into the filter RAM at addresses 0..N-1.
module fir_coeff_loader #(
    parameter int NUM_TAPS = 40,
    parameter int COEFF_W  = 16,
    parameter int ADDR_W   = 6,
    parameter int ARM_CYC  = 2,
    parameter int TIMEOUT  = 4095
) (
    input  logic              iClk12M,
    input  logic              iRsn,
    fir_coeff_loader_if.slave bus
);
    localparam int CNT_W = $clog2(NUM_TAPS + 1);
    localparam int ARM_W = $clog2(ARM_CYC + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_LOAD   = 2'd2,
        ST_SETTLE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               flag_q, flag_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               csn_q, csn_d;
    logic               wrn_q, wrn_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [COEFF_W-1:0] data_q, data_d;
    logic [15:0]        sum_q, sum_d;
    logic [CNT_W-1:0]   word_q, word_d;
    logic [ARM_W-1:0]   arm_q, arm_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;

    logic coeff_ready_s;
    logic accept_s;
    logic abort_s;

    // Ready is combinational so an abort in the same cycle blocks the word.
    assign coeff_ready_s = (state_q == ST_LOAD) & ~bus.iAbort;
    assign accept_s      = bus.iCoeffValid & coeff_ready_s;
    assign abort_s       = bus.iAbort & (state_q != ST_IDLE);

    // Next-state and next-output computation for the session sequencer.
    always_comb begin
        state_d = state_q;
        flag_d  = flag_q;
        busy_d  = busy_q;
        word_d  = word_q;
        arm_d   = arm_q;
        tmo_d   = tmo_q;
        sum_d   = sum_q;
        addr_d  = addr_q;
        data_d  = data_q;
        csn_d   = 1'b1;
        wrn_d   = 1'b1;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (abort_s) begin
            state_d = ST_IDLE;
            flag_d  = 1'b0;
            busy_d  = 1'b0;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.iStart) begin
                        state_d = ST_ARM;
                        flag_d  = 1'b1;
                        busy_d  = 1'b1;
                        word_d  = {CNT_W{1'b0}};
                        arm_d   = {ARM_W{1'b0}};
                        sum_d   = 16'h0000;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ARM: begin
                    if (arm_q == ARM_W'(ARM_CYC - 1)) begin
                        state_d = ST_LOAD;
                        tmo_d   = {TMO_W{1'b0}};
                    end else begin
                        arm_d = arm_q + ARM_W'(1);
                    end
                end
                ST_LOAD: begin
                    if (accept_s) begin
                        csn_d  = 1'b0;
                        wrn_d  = 1'b0;
                        addr_d = ADDR_W'(word_q);
                        data_d = bus.iCoeff;
                        word_d = word_q + CNT_W'(1);
                        sum_d  = sum_q + 16'(bus.iCoeff);
                        tmo_d  = {TMO_W{1'b0}};
                        if (word_q == CNT_W'(NUM_TAPS - 1)) begin
                            state_d = ST_SETTLE;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        // This idle cycle is the TIMEOUT-th in a row.
                        state_d = ST_IDLE;
                        flag_d  = 1'b0;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                        tmo_d   = {TMO_W{1'b0}};
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                ST_SETTLE: begin
                    state_d = ST_IDLE;
                    flag_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    flag_d  = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs, with synchronous reset.
    always_ff @(posedge iClk12M) begin
        if (iRsn) begin
            state_q <= ST_IDLE;
            flag_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            csn_q   <= 1'b1;
            wrn_q   <= 1'b1;
            addr_q  <= {ADDR_W{1'b0}};
            data_q  <= {COEFF_W{1'b0}};
            sum_q   <= 16'h0000;
            word_q  <= {CNT_W{1'b0}};
            arm_q   <= {ARM_W{1'b0}};
            tmo_q   <= {TMO_W{1'b0}};
        end else begin
            state_q <= state_d;
            flag_q  <= flag_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            csn_q   <= csn_d;
            wrn_q   <= wrn_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            sum_q   <= sum_d;
            word_q  <= word_d;
            arm_q   <= arm_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.oCoeffReady      = coeff_ready_s;
    assign bus.oCoeffUpdateFlag = flag_q;
    assign bus.oCsnRam          = csn_q;
    assign bus.oWrnRam          = wrn_q;
    assign bus.oAddrRam         = addr_q;
    assign bus.oWtDtRam         = data_q;
    assign bus.oBusy            = busy_q;
    assign bus.oDone            = done_q;
    assign bus.oErr             = err_q;
    assign bus.oChecksum        = sum_q;
endmodule

// File: tb/tb_fir_coeff_loader.sv
// Bench for fir_coeff_loader: directed session table, reset sequences and a
// randomized phase, all checked every cycle against a session-level model.
`timescale 1ns/1ps
module tb_fir_coeff_loader;
    localparam int NUM_TAPS = 40;
    localparam int ARM_CYC  = 2;
    localparam int TIMEOUT  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    fir_coeff_loader_if #(.COEFF_W(16), .ADDR_W(6)) bus ();

    fir_coeff_loader #(
        .NUM_TAPS(NUM_TAPS), .COEFF_W(16), .ADDR_W(6),
        .ARM_CYC(ARM_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .iClk12M(clk),
        .iRsn   (rst),
        .bus    (bus)
    );

    always #42 clk = ~clk;

    // Reference model: session bookkeeping in cycle numbers and word counts.
    bit          m_busy = 1'b0;
    bit          m_pw = 1'b0;
    bit          m_done = 1'b0;
    bit          m_err = 1'b0;
    int          m_start = 0;
    int          m_ref = 0;
    int          m_nacc = 0;
    logic [5:0]  m_addr = 6'd0;
    logic [15:0] m_data = 16'h0000;
    logic [15:0] m_sum = 16'h0000;

    int s_writes, s_done_cyc, s_err_cyc, s_ready_cyc, s_flag_cyc, s_acc_cyc;
    bit s_done, s_err;

    typedef struct {
        int          mode;      // 0 valid always, 1 every other cycle, 2 stop after stop_n words
        logic [15:0] base;
        logic [15:0] inc;
        int          abort_w;   // word index aborted with 0x1234 offered; -2 abort in ARM; -1 none
        int          stop_n;
        bit          mid_start;
        int          exp_writes;
        logic [15:0] exp_sum;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    vec_t tbl[6];

    function automatic logic [44:0] out_vec();
        return {bus.oCoeffUpdateFlag, bus.oBusy, bus.oCoeffReady, bus.oCsnRam, bus.oWrnRam,
                bus.oAddrRam, bus.oWtDtRam, bus.oDone, bus.oErr, bus.oChecksum};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic stats_clear();
        s_writes = 0; s_done = 1'b0; s_err = 1'b0;
        s_done_cyc = -1; s_err_cyc = -1; s_ready_cyc = -1; s_flag_cyc = -1; s_acc_cyc = -1;
    endtask

    task automatic model_step();
        int load_at;
        if (rst) begin
            m_busy = 1'b0; m_pw = 1'b0; m_done = 1'b0; m_err = 1'b0;
            m_addr = 6'd0; m_data = 16'h0000; m_sum = 16'h0000; m_nacc = 0;
            return;
        end
        load_at = m_start + 1 + ARM_CYC;
        m_pw = 1'b0; m_done = 1'b0; m_err = 1'b0;
        if (!m_busy) begin
            if (bus.iStart) begin
                m_busy = 1'b1; m_start = cyc; m_nacc = 0; m_sum = 16'h0000;
                m_ref = cyc + 1 + ARM_CYC;
            end
        end else if (bus.iAbort) begin
            m_busy = 1'b0; m_err = 1'b1;
        end else if (m_nacc == NUM_TAPS) begin
            m_busy = 1'b0; m_done = 1'b1;
        end else if (cyc >= load_at) begin
            if (bus.iCoeffValid) begin
                m_pw = 1'b1; m_addr = 6'(m_nacc); m_data = bus.iCoeff;
                m_nacc++; m_sum = m_sum + bus.iCoeff; m_ref = cyc + 1;
            end else if (cyc - m_ref + 1 >= TIMEOUT) begin
                m_busy = 1'b0; m_err = 1'b1;
            end
        end
    endtask

    task automatic tick(input bit do_chk);
        logic [44:0] exp_v;
        bit          exp_rdy;
        @(negedge clk);
        exp_rdy = m_busy && (cyc >= m_start + 1 + ARM_CYC) && (m_nacc < NUM_TAPS) && !bus.iAbort;
        exp_v = {m_busy, m_busy, exp_rdy, !m_pw, !m_pw, m_addr, m_data, m_done, m_err, m_sum};
        if (do_chk) chk($sformatf("cycle%0d", cyc), 64'(out_vec()), 64'(exp_v));
        if (bus.oCsnRam == 1'b0 && bus.oWrnRam == 1'b0) s_writes++;
        if (bus.oDone) begin s_done = 1'b1; s_done_cyc = cyc; end
        if (bus.oErr) begin s_err = 1'b1; s_err_cyc = cyc; end
        if (bus.oCoeffReady && s_ready_cyc < 0) s_ready_cyc = cyc;
        if (bus.oCoeffUpdateFlag && s_flag_cyc < 0) s_flag_cyc = cyc;
        if (bus.oCoeffReady && bus.iCoeffValid) s_acc_cyc = cyc;
        model_step();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.iStart = 1'b0; bus.iAbort = 1'b0; bus.iCoeffValid = 1'b0; bus.iCoeff = 16'h0000;
    endtask

    task automatic run_session(input int idx, input vec_t v);
        int t;
        int k;
        int word;
        stats_clear();
        bus.iStart = 1'b1;
        t = cyc;
        tick(1'b1);
        bus.iStart = 1'b0;
        k = 0;
        while (m_busy && k < 600) begin
            word = m_nacc;
            case (v.mode)
                1:       bus.iCoeffValid = (k % 2 == 0);
                2:       bus.iCoeffValid = (word < v.stop_n);
                default: bus.iCoeffValid = 1'b1;
            endcase
            bus.iCoeff  = (word == v.abort_w) ? 16'h1234 : 16'(v.base + v.inc * 16'(word));
            bus.iAbort  = (v.abort_w >= 0 && word == v.abort_w && bus.iCoeffValid) ||
                          (v.abort_w == -2 && k == 1);
            bus.iStart  = v.mid_start && (word == 20);
            tick(1'b1);
            k++;
        end
        if (k >= 600) begin
            n_vec++; n_err++;
            $display("FAIL budget%0d: session still busy after %0d cycles, required idle", idx, k);
        end
        idle_inputs();
        tick(1'b1);
        tick(1'b1);
        chk($sformatf("writes%0d", idx), 64'(s_writes), 64'(v.exp_writes));
        chk($sformatf("checksum%0d", idx), 64'(bus.oChecksum), 64'(v.exp_sum));
        chk($sformatf("done%0d", idx), 64'(s_done), 64'(v.exp_done));
        chk($sformatf("err%0d", idx), 64'(s_err), 64'(v.exp_err));
        chk($sformatf("flag_lat%0d", idx), 64'(s_flag_cyc - t), 64'(1));
        if (v.exp_writes > 0)
            chk($sformatf("ready_lat%0d", idx), 64'(s_ready_cyc - t), 64'(ARM_CYC + 1));
        if (v.exp_done)
            chk($sformatf("done_lat%0d", idx), 64'(s_done_cyc - s_acc_cyc), 64'(2));
        if (v.exp_err && v.stop_n > 0)
            chk($sformatf("tmo_lat%0d", idx), 64'(s_err_cyc - s_acc_cyc), 64'(TIMEOUT + 1));
    endtask

    initial begin
        logic [44:0] reset_v;
        int          k;
        int          pv;
        reset_v = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 16'h0000, 1'b0, 1'b0, 16'h0000};
        tbl[0] = '{0, 16'h0001, 16'h0001, -1, 0, 1'b0, 40, 16'h0334, 1'b1, 1'b0};
        tbl[1] = '{1, 16'hFFFF, 16'h0000, -1, 0, 1'b0, 40, 16'hFFD8, 1'b1, 1'b0};
        tbl[2] = '{0, 16'h0001, 16'h0001, 10, 0, 1'b0, 10, 16'h0037, 1'b0, 1'b1};
        tbl[3] = '{2, 16'h0001, 16'h0001, -1, 5, 1'b0, 5, 16'h000F, 1'b0, 1'b1};
        tbl[4] = '{0, 16'h0100, 16'h0001, -1, 0, 1'b1, 40, 16'h2B0C, 1'b1, 1'b0};
        tbl[5] = '{0, 16'h0001, 16'h0001, -2, 0, 1'b0, 0, 16'h0000, 1'b0, 1'b1};

        // Reset held three cycles with random inputs.
        rst = 1'b1;
        stats_clear();
        for (int i = 0; i < 3; i++) begin
            bus.iStart = 1'($urandom); bus.iAbort = 1'($urandom);
            bus.iCoeffValid = 1'($urandom); bus.iCoeff = 16'($urandom);
            tick(i > 0);
        end
        chk("reset_vec", 64'(out_vec()), 64'(reset_v));
        chk("reset_writes", 64'(s_writes), 64'(0));
        rst = 1'b0;
        idle_inputs();
        tick(1'b1);

        for (int i = 0; i < 6; i++) run_session(i, tbl[i]);

        // Reset in the middle of LOAD: idle next cycle, no error or done pulse.
        stats_clear();
        bus.iStart = 1'b1;
        tick(1'b1);
        bus.iStart = 1'b0;
        bus.iCoeffValid = 1'b1;
        k = 0;
        while (m_nacc < 5 && k < 50) begin
            bus.iCoeff = 16'(16'h0050 + 16'(m_nacc));
            tick(1'b1);
            k++;
        end
        rst = 1'b1;
        tick(1'b1);
        rst = 1'b0;
        idle_inputs();
        stats_clear();
        chk("midrst_idle", 64'(out_vec()), 64'(reset_v));
        for (int i = 0; i < 3; i++) tick(1'b1);
        chk("midrst_err", 64'(s_err), 64'(0));
        chk("midrst_done", 64'(s_done), 64'(0));

        // Randomized traffic with varying valid density.
        for (int seg = 0; seg < 12; seg++) begin
            case (seg % 4)
                0:       pv = 100;
                1:       pv = 60;
                2:       pv = 15;
                default: pv = 3;
            endcase
            for (int c = 0; c < 250; c++) begin
                rst             = ($urandom_range(0, 599) == 0);
                bus.iStart      = ($urandom_range(0, 15) == 0);
                bus.iAbort      = ($urandom_range(0, 149) == 0);
                bus.iCoeffValid = ($urandom_range(0, 99) < pv);
                bus.iCoeff      = 16'($urandom);
                tick(1'b1);
            end
        end
        rst = 1'b0;
        idle_inputs();
        tick(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
